// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and direction constants for the counter sweep sequencer
package counter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UP,
    DOWN,
    HOLD,
    DONE
  } sweep_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - clock divider producing one tick every div clocks (div of 0 acts as 1)
module tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  assign last = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick = !clear && (cnt == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - presets the counter and ramps it lo->hi->lo for N sweeps or until abort
// Endpoint dwell of HOLD_CYC ticks is enabled by defining SWEEP_HOLD_EN.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 8,
  parameter int SWEEP_W  = 8,
  parameter int HOLD_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [DIV_W-1:0]   div,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic               cnt_preset,
  output logic [WIDTH-1:0]   cnt_load,
  output logic               cnt_en,
  output logic               cnt_dir,
  output logic [WIDTH-1:0]   shadow_count,
  output logic [SWEEP_W-1:0] sweep_idx,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

`ifdef SWEEP_HOLD_EN
  localparam logic USE_HOLD = 1'b1;
`else
  localparam logic USE_HOLD = 1'b0;
`endif
  localparam int HOLD_N = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int HOLD_W = $clog2(HOLD_N + 1);

  sweep_state_e       state;
  logic [WIDTH-1:0]   lo_q, hi_q, nxt_shadow;
  logic [DIV_W-1:0]   div_q;
  logic [SWEEP_W-1:0] sweeps_q, sweep_inc;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               hold_dir, fin, last_sweep, running, tick;

  assign running    = state inside {LOAD, UP, DOWN, HOLD};
  assign sweep_inc  = sweep_idx + SWEEP_W'(1);
  assign last_sweep = (sweeps_q != '0) && (sweep_inc == sweeps_q);

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (!running),
    .div   (div_q),
    .tick  (tick)
  );

  // Counter value during the next cycle; step decisions look one cycle ahead so the
  // registered cnt_en lands in the tick cycle itself.
  always_comb begin
    nxt_shadow = shadow_count;
    if (cnt_preset) begin
      nxt_shadow = cnt_load;
    end else if (cnt_en) begin
      nxt_shadow = (cnt_dir == DIR_UP) ? shadow_count + WIDTH'(1) : shadow_count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      div_q        <= '0;
      sweeps_q     <= '0;
      hold_cnt     <= '0;
      hold_dir     <= DIR_UP;
      fin          <= 1'b0;
      cnt_preset   <= 1'b0;
      cnt_load     <= '0;
      cnt_en       <= 1'b0;
      cnt_dir      <= DIR_UP;
      shadow_count <= '0;
      sweep_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      shadow_count <= nxt_shadow;
      cnt_preset   <= 1'b0;
      cnt_en       <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        fin   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (lo_lim < hi_lim) begin
                lo_q       <= lo_lim;
                hi_q       <= hi_lim;
                div_q      <= div;
                sweeps_q   <= sweeps;
                cnt_preset <= 1'b1;
                cnt_load   <= lo_lim;
                sweep_idx  <= '0;
                fin        <= 1'b0;
                busy       <= 1'b1;
                state      <= LOAD;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          LOAD, UP: begin
            state <= UP;
            if (tick) begin
              if (nxt_shadow < hi_q) begin
                cnt_en  <= 1'b1;
                cnt_dir <= DIR_UP;
              end else begin
                hold_cnt <= HOLD_W'(1);
                hold_dir <= DIR_DOWN;
                state    <= USE_HOLD ? HOLD : DOWN;
              end
            end
          end
          DOWN: begin
            if (fin) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else if (tick) begin
              if (nxt_shadow > lo_q) begin
                cnt_en  <= 1'b1;
                cnt_dir <= DIR_DOWN;
              end else begin
                sweep_idx <= sweep_inc;
                fin       <= last_sweep;
                hold_cnt  <= HOLD_W'(1);
                hold_dir  <= DIR_UP;
                state     <= USE_HOLD ? HOLD : (last_sweep ? DOWN : UP);
              end
            end
          end
          HOLD: begin
            if (hold_cnt >= HOLD_W'(HOLD_N)) begin
              if (fin) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else if (tick) begin
                cnt_en  <= 1'b1;
                cnt_dir <= hold_dir;
                state   <= (hold_dir == DIR_UP) ? UP : DOWN;
              end
            end else if (tick) begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - scoreboard bench for counter_sweep_ctrl driving a behavioural up/down counter
module tb_counter_sweep_ctrl;

  localparam int K_PRE  = 0;
  localparam int K_UP   = 1;
  localparam int K_DN   = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;
`ifdef SWEEP_HOLD_EN
  localparam int DW = 4;
`else
  localparam int DW = 1;
`endif

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] lo_lim = '0;
  logic [7:0] hi_lim = '0;
  logic [7:0] div = '0;
  logic [7:0] sweeps = '0;
  logic       cnt_preset, cnt_en, cnt_dir, busy, done, cfg_err;
  logic [7:0] cnt_load, shadow_count, sweep_idx;
  logic [7:0] model_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int last_done = -1;

  counter_sweep_ctrl #(
    .WIDTH(8), .DIV_W(8), .SWEEP_W(8), .HOLD_CYC(4)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .start        (start),
    .abort        (abort),
    .lo_lim       (lo_lim),
    .hi_lim       (hi_lim),
    .div          (div),
    .sweeps       (sweeps),
    .cnt_preset   (cnt_preset),
    .cnt_load     (cnt_load),
    .cnt_en       (cnt_en),
    .cnt_dir      (cnt_dir),
    .shadow_count (shadow_count),
    .sweep_idx    (sweep_idx),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The controlled counter: preset loads, en steps in the requested direction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_cnt <= '0;
    else if (cnt_preset) model_cnt <= cnt_load;
    else if (cnt_en) model_cnt <= cnt_dir ? model_cnt + 8'd1 : model_cnt - 8'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int   mk, mv, mrel;
  ev_t  me;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count_mirror", shadow_count, model_cnt);
      if (cnt_preset || cnt_en || done || cfg_err) begin
        mrel = cyc - base;
        if (cnt_preset) begin
          mk = K_PRE; mv = cnt_load;
        end else if (cnt_en) begin
          mk = cnt_dir ? K_UP : K_DN; mv = shadow_count;
        end else if (done) begin
          mk = K_DONE; mv = sweep_idx; last_done = mrel;
        end else begin
          mk = K_ERR; mv = 0;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_event_kind", mk, -1);
        end else begin
          me = exp_q.pop_front();
          chk("event_kind", mk, me.kind);
          chk("event_cycle", mrel, me.cyc);
          chk("event_value", mv, me.val);
        end
      end
    end
  end

  task automatic push(input int kind, input int c, input int v, input int limit);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = v;
    if (c <= limit) exp_q.push_back(e);
  endtask

  // Tick m lands in cycle 1+div*m; each turnaround consumes DW ticks with no step.
  task automatic push_run(input int lo, input int hi, input int dv, input int nsw,
                          input bit with_done, input int limit);
    int m;
    int d;
    d = (dv == 0) ? 1 : dv;
    m = 1;
    push(K_PRE, 1, lo, limit);
    for (int s = 0; s < nsw; s++) begin
      for (int v = lo; v < hi; v++) begin push(K_UP, 1 + d * m, v, limit); m++; end
      m += DW;
      for (int v = hi; v > lo; v--) begin push(K_DN, 1 + d * m, v, limit); m++; end
      m += DW;
    end
    if (with_done) push(K_DONE, 2 + d * (m - 1), nsw % 256, limit);
  endtask

  task automatic do_start(input int lo, input int hi, input int dv, input int sw);
    @(negedge clk);
    lo_lim = 8'(lo); hi_lim = 8'(hi); div = 8'(dv); sweeps = 8'(sw);
    start = 1'b1;
    base = cyc;
    @(negedge clk);
    start = 1'b0;
    lo_lim = 8'd0; hi_lim = 8'd200; div = 8'd7; sweeps = 8'd9;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
    chk({name, "_busy"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int abort_cyc;
    int rst_cyc;
    int per;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_dir", cnt_dir, 1);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_preset", cnt_preset, 0);
    chk("rst_shadow", shadow_count, 0);
    chk("rst_sweep_idx", sweep_idx, 0);
    chk("rst_cnt_load", cnt_load, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // one sweep, div=1; stray start mid-run must be ignored
    push_run(2, 5, 1, 1, 1'b1, 100000);
    do_start(2, 5, 1, 1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("t1_drain", 100);
    chk("t1_done_cycle", last_done, (DW == 1) ? 10 : 16);
    chk("t1_sweep_idx", sweep_idx, 1);

    // div=3
    push_run(2, 5, 3, 1, 1'b1, 100000);
    do_start(2, 5, 3, 1);
    drain("t2_drain", 200);
    chk("t2_done_cycle", last_done, (DW == 1) ? 26 : 44);

    // rejected configurations
    push(K_ERR, 1, 0, 100000);
    do_start(5, 5, 1, 1);
    chk("t3_busy_eq", busy, 0);
    drain("t3_drain_eq", 10);
    push(K_ERR, 1, 0, 100000);
    do_start(7, 3, 1, 1);
    chk("t3_busy_gt", busy, 0);
    drain("t3_drain_gt", 10);

    // continuous run, abort on the second step of sweep 4
    per = 2 * (5 - 2) + 2 * DW;
    abort_cyc = 1 + (1 + 3 * per + 1);
    push_run(2, 5, 1, 4, 1'b0, abort_cyc);
    do_start(2, 5, 1, 0);
    while (cyc - base < abort_cyc && cyc - base < 1000) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_cnt_en", cnt_en, 0);
    chk("t4_done", done, 0);
    chk("t4_sweep_idx", sweep_idx, 3);
    chk("t4_queue", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk("t4_still_idle", busy, 0);

    // reset during the second down step, then a clean rerun
    rst_cyc = 1 + (1 + (4 - 1) + DW + 1);
    push_run(1, 4, 1, 1, 1'b0, rst_cyc);
    do_start(1, 4, 1, 1);
    while (cyc - base < rst_cyc && cyc - base < 1000) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_cnt_en", cnt_en, 0);
    chk("t5_cnt_preset", cnt_preset, 0);
    chk("t5_cnt_dir", cnt_dir, 1);
    chk("t5_shadow", shadow_count, 0);
    chk("t5_sweep_idx", sweep_idx, 0);
    chk("t5_cnt_load", cnt_load, 0);
    chk("t5_queue", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_run(1, 4, 1, 1, 1'b1, 100000);
    do_start(1, 4, 1, 1);
    drain("t5_rerun_drain", 100);
    chk("t5_rerun_sweep_idx", sweep_idx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
